cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Sequencer and arbiter that shares the single cache port of the memory subsystem between the instruction-fetch requester and the data load/store requester. It grants one requester at a time and drives address, write data and opcode into the cache. It holds the grant across multi-cycle misses until the cache reports `hit`, then returns the read word with a one-cycle `ready` pulse. It sits between the processor's fetch/memory stages and `memory_cache`, and includes a starvation guard and a miss watchdog.

## Interface
- `STARVE_LIMIT`, 3: consecutive data grants allowed while fetch is pending before fetch is forced.
- `MAX_WAIT`, 255: cycles a grant may wait for `hit` before the watchdog aborts it.
- `LW_OPCODE`, 6'h23: opcode presented to the cache for instruction fetches.
- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held until `if_ready`.
- `if_addr` in 32: fetch address.
- `if_rdata` out [7:0]x[0:3]: fetched word, valid while `if_ready`.
- `if_ready` out 1: one-cycle completion pulse for a fetch.
- `d_req` in 1: data request; held until `d_ready`.
- `d_opcode` in 6: memory opcode (lw/sw/lb/sb).
- `d_addr` in 32: data address.
- `d_wdata` in [7:0]x[0:3]: store data.
- `d_rdata` out [7:0]x[0:3]: load data, valid while `d_ready`.
- `d_ready` out 1: one-cycle completion pulse for a data access.
- `c_addr` out 32: cache address.
- `c_data_in` out [7:0]x[0:3]: cache write data.
- `c_opcode` out 6: cache opcode; 6'h00 (non-memory) when idle.
- `c_data_out` in [7:0]x[0:3]: cache read data.
- `c_hit` in 1: access complete.
- `timeout` out 1: sticky watchdog error flag; cleared only by reset.

## Operation
- States: IDLE, GNT_IF, GNT_D.
- IDLE:
  - both requests low: stay in IDLE.
  - only one request: grant it.
  - both requests: grant data, unless `starve_cnt == STARVE_LIMIT`, in which case grant fetch.
- In GNT_IF, the cache sees `c_addr = if_addr`, `c_opcode = LW_OPCODE`, `c_data_in` = 0.
- In GNT_D, the cache sees `d_addr`, `d_opcode`, `d_wdata`.
- In IDLE, `c_opcode` = 6'h00 and `c_addr` / `c_data_in` = 0. Cache inputs are combinational from state plus the held request.
- In a grant state with `c_hit` = 1 at a clock edge:
  - register `c_data_out` into the granted `*_rdata`.
  - pulse the granted `*_ready` next cycle.
  - return to IDLE.
- `starve_cnt` (clog2(STARVE_LIMIT+1) bits):
  - increments on each data completion while `if_req` is high, saturating at `STARVE_LIMIT`.
  - clears on any fetch completion, and whenever `if_req` is low.
- `wait_cnt` (8 bits min):
  - clears on entering a grant state and increments each grant cycle without hit.
  - at `MAX_WAIT`: set `timeout`, pulse the granted `*_ready` with `*_rdata` = 0, return to IDLE.
- Requests dropped mid-grant are illegal; the behaviour is undefined and is flagged by an assertion.
- Reset mid-grant aborts the access; no `ready` pulse is issued.

## Timing
- Reset values: state IDLE, `if_ready` = `d_ready` = 0, `*_rdata` = 0, `c_opcode` = 6'h00, `c_addr` = 0, `c_data_in` = 0, `timeout` = 0, counters = 0.
- Request high at edge N (IDLE): grant from cycle N+1.
- Hit during grant cycle N+k, sampled at the edge ending that cycle: `ready` high for exactly one cycle after that edge, with data stable in the same cycle.
- Minimum request-to-ready latency is 2 cycles (hit in the first grant cycle).
- The cycle carrying `ready` is IDLE. A requester may drop or re-raise its request there; a new grant is at earliest the following cycle, so there is at most one access per 2 cycles.
- `c_hit` is ignored in IDLE.
- If hit and `wait_cnt == MAX_WAIT` occur on the same edge, hit wins: normal completion, no timeout.

## Structure
- A shared package holds:
  - the state enum `arb_state_t`.
  - opcode constants `OP_NONE`, `OP_LW`, `OP_SW`, `OP_LB`, `OP_SB`.
  - the `word_t` byte-array typedef.
- One sub-module, `arb_starve_counter`, holds the saturating `starve_cnt` logic and outputs `force_if`.
- Everything else is flat.

## Test plan
- Fetch only, `if_addr` = 32'h40, `c_hit` high immediately: `c_opcode` = 6'h23 in cycle 1; `if_ready` pulses in cycle 2 with the word.
- Data sw, `d_addr` = 32'h100, `c_hit` delayed 5 cycles (miss plus writeback): `c_addr` and `d_wdata` held stable for 6 cycles; single `d_ready` pulse; `if_ready` never asserts.
- Both requesters continuously high, `STARVE_LIMIT` = 3, hit in 1 cycle: grant order D, D, D, IF, D, D, D, IF.
- `c_hit` never asserted, `MAX_WAIT` = 4: `d_ready` pulses after 4 grant cycles with `d_rdata` = 0; `timeout` = 1 and stays 1.
- `rst_b` pulled low during the 3rd cycle of a pending miss: all outputs reset asynchronously; no `ready` pulse; a new fetch after reset completes normally.
- Hit and watchdog expiry on the same edge: normal data returned, `timeout` stays 0.

Source files
------------

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and constants for the cache port arbiter: grant states,
// memory opcodes and the four-byte word type exchanged with the cache.
package cache_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2
    } arb_state_t;

    localparam logic [5:0] OP_NONE = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_LB   = 6'h20;
    localparam logic [5:0] OP_SB   = 6'h28;

    // Byte 0 sits in the most significant position of the packed word.
    typedef logic [0:3][7:0] word_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts back-to-back data completions while a fetch waits; once the count
// saturates at STARVE_LIMIT the next arbitration must go to the fetch side.
module arb_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst_b,
    input  logic if_req,
    input  logic if_done,
    input  logic d_done,
    output logic force_if
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_done) begin
            starve_cnt_d = '0;
        end else if (d_done && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_if = (starve_cnt_q == LIMIT);

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single cache port between instruction fetch and data load/store,
// holding each grant across misses until hit, with starvation guard and watchdog.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned MAX_WAIT     = 255,
    parameter logic [5:0]  LW_OPCODE    = 6'h23
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output word_t       if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic [5:0]  d_opcode,
    input  logic [31:0] d_addr,
    input  word_t       d_wdata,
    output word_t       d_rdata,
    output logic        d_ready,
    output logic [31:0] c_addr,
    output word_t       c_data_in,
    output logic [5:0]  c_opcode,
    input  word_t       c_data_out,
    input  logic        c_hit,
    output logic        timeout
);

    localparam int unsigned WAIT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    // wait_cnt holds the miss cycles already elapsed; the grant expires on the
    // MAX_WAIT-th consecutive miss cycle, i.e. when the count would reach MAX_WAIT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    word_t             if_rdata_q, if_rdata_d;
    word_t             d_rdata_q, d_rdata_d;
    logic              timeout_q, timeout_d;
    logic              force_if;
    logic              expire;
    word_t             ret_word;

    assign expire   = !c_hit && (wait_cnt_q == WAIT_LAST);
    assign ret_word = c_hit ? c_data_out : '0;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (if_req && (!d_req || force_if)) begin
                    state_d = GNT_IF;
                end else if (d_req) begin
                    state_d = GNT_D;
                end
            end
            GNT_IF, GNT_D: begin
                // Hit has priority over an expiry on the same edge.
                if (c_hit || expire) begin
                    state_d = IDLE;
                    if (!c_hit) timeout_d = 1'b1;
                    if (state_q == GNT_IF) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = ret_word;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = ret_word;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the read-data holding registers are reset too, so they read zero until the first completion.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            timeout_q  <= timeout_d;
        end
    end

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_b   (rst_b),
        .if_req  (if_req),
        .if_done (if_ready_d),
        .d_done  (d_ready_d),
        .force_if(force_if)
    );

    // The cache sees the held request of whoever owns the port.
    always_comb begin
        c_addr    = '0;
        c_data_in = '0;
        c_opcode  = OP_NONE;
        unique case (state_q)
            GNT_IF: begin
                c_addr   = if_addr;
                c_opcode = LW_OPCODE;
            end
            GNT_D: begin
                c_addr    = d_addr;
                c_data_in = d_wdata;
                c_opcode  = d_opcode;
            end
            default: ;
        endcase
    end

    assign if_ready = if_ready_q;
    assign d_ready  = d_ready_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign timeout  = timeout_q;

`ifndef SYNTHESIS
    // A requester must keep its request up for the whole grant.
    a_if_held: assert property (@(posedge clk) disable iff (!rst_b) (state_q == GNT_IF) |-> if_req);
    a_d_held:  assert property (@(posedge clk) disable iff (!rst_b) (state_q == GNT_D) |-> d_req);
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed scenarios plus a random
// run, all compared against a transaction-level reference model.
module tb_cache_port_arbiter;
    import cache_port_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 3;
    localparam int MAX_WAIT     = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    word_t       if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic [5:0]  d_opcode = OP_NONE;
    logic [31:0] d_addr = '0;
    word_t       d_wdata = '0;
    word_t       d_rdata;
    logic        d_ready;
    logic [31:0] c_addr;
    word_t       c_data_in;
    logic [5:0]  c_opcode;
    word_t       c_data_out = '0;
    logic        c_hit = 1'b0;
    logic        timeout;

    // Second instance with the default watchdog for the long-miss scenario.
    logic        if_req_l = 1'b0;
    logic        d_req_l = 1'b0;
    logic        c_hit_l = 1'b0;
    word_t       if_rdata_l, d_rdata_l, c_data_in_l;
    logic        if_ready_l, d_ready_l, timeout_l;
    logic [31:0] c_addr_l;
    logic [5:0]  c_opcode_l;

    always #5 clk = ~clk;

    cache_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_WAIT(MAX_WAIT), .LW_OPCODE(6'h23)) u_dut (
        .clk(clk), .rst_b(rst_b),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_opcode(d_opcode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .c_addr(c_addr), .c_data_in(c_data_in), .c_opcode(c_opcode),
        .c_data_out(c_data_out), .c_hit(c_hit), .timeout(timeout)
    );

    cache_port_arbiter u_dut_long (
        .clk(clk), .rst_b(rst_b),
        .if_req(if_req_l), .if_addr(if_addr), .if_rdata(if_rdata_l), .if_ready(if_ready_l),
        .d_req(d_req_l), .d_opcode(d_opcode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_l), .d_ready(d_ready_l),
        .c_addr(c_addr_l), .c_data_in(c_data_in_l), .c_opcode(c_opcode_l),
        .c_data_out(c_data_out), .c_hit(c_hit_l), .timeout(timeout_l)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how many miss cycles it has spent,
    // how many data completions in a row have passed a waiting fetch.
    int    m_owner;   // 0 none, 1 fetch, 2 data
    int    m_misses;
    int    m_streak;
    bit    m_timeout, m_if_ready, m_d_ready;
    word_t m_if_rdata, m_d_rdata;

    function automatic void model_reset();
        m_owner = 0; m_misses = 0; m_streak = 0;
        m_timeout = 0; m_if_ready = 0; m_d_ready = 0;
        m_if_rdata = '0; m_d_rdata = '0;
    endfunction

    function automatic void model_edge();
        int    next_streak;
        word_t w;
        if (!rst_b) begin
            model_reset();
            return;
        end
        m_if_ready = 0;
        m_d_ready = 0;
        next_streak = m_streak;
        if (m_owner == 0) begin
            if (if_req && (!d_req || m_streak == STARVE_LIMIT)) m_owner = 1;
            else if (d_req) m_owner = 2;
            m_misses = 0;
        end else if (c_hit || (m_misses + 1 == MAX_WAIT)) begin
            w = c_hit ? c_data_out : '0;
            if (!c_hit) m_timeout = 1;
            if (m_owner == 1) begin
                m_if_ready = 1; m_if_rdata = w; next_streak = 0;
            end else begin
                m_d_ready = 1; m_d_rdata = w;
                next_streak = (m_streak < STARVE_LIMIT) ? m_streak + 1 : STARVE_LIMIT;
            end
            m_owner = 0;
        end else begin
            m_misses++;
        end
        m_streak = if_req ? next_streak : 0;
    endfunction

    task automatic check_outputs();
        logic [5:0]  e_op;
        logic [31:0] e_addr;
        word_t       e_wd;
        e_op = OP_NONE; e_addr = '0; e_wd = '0;
        if (m_owner == 1) begin
            e_op = 6'h23; e_addr = if_addr;
        end else if (m_owner == 2) begin
            e_op = d_opcode; e_addr = d_addr; e_wd = d_wdata;
        end
        check("c_opcode", c_opcode, e_op);
        check("c_addr", c_addr, e_addr);
        check("c_data_in", c_data_in, e_wd);
        check("if_ready", if_ready, m_if_ready);
        check("d_ready", d_ready, m_d_ready);
        check("timeout", timeout, m_timeout);
        if (m_if_ready) check("if_rdata", if_rdata, m_if_rdata);
        if (m_d_ready) check("d_rdata", d_rdata, m_d_rdata);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #2;
        check_outputs();
    endtask

    task automatic apply_reset();
        if_req = 0; d_req = 0; c_hit = 0; d_req_l = 0; c_hit_l = 0;
        rst_b = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_b = 1;
        #1 check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        word_t       w;
        int          gcyc, held, dp, ip, npulse;
        bit          seen;
        logic [7:0]  order;

        // Reset state.
        apply_reset();
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);

        // Fetch with an immediate hit.
        apply_reset();
        w = $urandom; c_data_out = w; c_hit = 1; if_req = 1; if_addr = 32'h40;
        cycle();
        check("f_opcode_c1", c_opcode, 6'h23);
        check("f_addr_c1", c_addr, 32'h40);
        cycle();
        check("f_ready_c2", if_ready, 1);
        check("f_rdata_c2", if_rdata, w);
        if_req = 0;
        cycle();
        check("f_ready_c3", if_ready, 0);

        // Store that misses for 5 cycles, on the default-watchdog instance.
        apply_reset();
        w = $urandom; c_data_out = w;
        d_req_l = 1; d_opcode = OP_SW; d_addr = 32'h100; d_wdata = $urandom;
        held = 0; dp = 0; ip = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (c_opcode_l == OP_SW && c_addr_l == 32'h100 && c_data_in_l == d_wdata) held++;
            if (d_ready_l) begin
                dp++;
                check("sw_rdata", d_rdata_l, w);
                d_req_l = 0;
            end
            if (if_ready_l) ip++;
            c_hit_l = (held >= 6);
        end
        check("sw_held_cycles", held, 6);
        check("sw_d_ready_pulses", dp, 1);
        check("sw_if_ready_pulses", ip, 0);
        check("sw_timeout", timeout_l, 0);

        // Both requesters always high: grant order D,D,D,IF,D,D,D,IF.
        apply_reset();
        if_req = 1; d_req = 1; c_hit = 1; d_opcode = OP_LW;
        if_addr = $urandom; d_addr = $urandom;
        order = '0; npulse = 0;
        for (int i = 0; i < 40 && npulse < 8; i++) begin
            cycle();
            if (d_ready || if_ready) begin
                order = {order[6:0], if_ready};
                npulse++;
            end
            c_data_out = $urandom;
        end
        check("starve_pulses", npulse, 8);
        check("starve_order", order, 8'b0001_0001);

        // Cache never hits: watchdog aborts after MAX_WAIT grant cycles.
        apply_reset();
        c_data_out = $urandom; d_req = 1; d_opcode = OP_LB; d_addr = $urandom;
        gcyc = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (c_opcode == OP_LB) gcyc++;
            if (d_ready) begin
                seen = 1;
                check("wd_rdata", d_rdata, 0);
                check("wd_timeout", timeout, 1);
                d_req = 0;
            end
        end
        check("wd_seen", seen, 1);
        check("wd_grant_cycles", gcyc, MAX_WAIT);
        repeat (3) cycle();
        check("wd_sticky", timeout, 1);

        // Hit on the same edge the watchdog would expire: hit wins.
        apply_reset();
        w = $urandom; c_data_out = w; d_req = 1; d_opcode = OP_LW; d_addr = $urandom;
        gcyc = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (c_opcode == OP_LW) gcyc++;
            if (d_ready) begin
                seen = 1;
                check("edge_rdata", d_rdata, w);
                check("edge_timeout", timeout, 0);
                d_req = 0;
            end
            c_hit = (gcyc == MAX_WAIT);
        end
        check("edge_seen", seen, 1);
        c_hit = 0;
        cycle();

        // Reset asserted in the 3rd cycle of a pending fetch miss.
        apply_reset();
        if_req = 1; if_addr = $urandom;
        repeat (3) cycle();
        #2 rst_b = 0;
        model_reset();
        if_req = 0;
        #1;
        check("rst_async_opcode", c_opcode, OP_NONE);
        check("rst_async_addr", c_addr, 0);
        check_outputs();
        cycle();
        rst_b = 1;
        repeat (3) cycle();
        w = $urandom; c_data_out = w; c_hit = 1; if_req = 1; if_addr = $urandom;
        cycle();
        cycle();
        check("rst_refetch_ready", if_ready, 1);
        check("rst_refetch_rdata", if_rdata, w);
        if_req = 0;
        cycle();

        // Randomised traffic against the model.
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            cycle();
            if (!if_req || m_if_ready) begin
                if_req = 1'($urandom_range(0, 1));
                if_addr = $urandom;
            end
            if (!d_req || m_d_ready) begin
                d_req = 1'($urandom_range(0, 1));
                d_addr = $urandom;
                d_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0: d_opcode = OP_LW;
                    1: d_opcode = OP_SW;
                    2: d_opcode = OP_LB;
                    default: d_opcode = OP_SB;
                endcase
            end
            c_hit = ($urandom_range(0, 2) == 0);
            c_data_out = $urandom;
        end
        if_req = 0; d_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
